// File: rtl/grid_paint_writer.sv
// Consumer end of the grid paint interface: buffers paint beats and serialises them into
// frame-buffer writes, sweeping the buffer clear on reset/clear_req. Option: GRID_PAINT_BORDER_EN.
module grid_paint_writer #(
  parameter int unsigned GRID_W       = 64,
  parameter int unsigned GRID_H       = 64,
  parameter int unsigned COLOR_W      = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [COLOR_W-1:0] BG_COLOR     = '0,
  parameter logic [COLOR_W-1:0] BORDER_COLOR = '1,
  localparam int unsigned XW = $clog2(GRID_W),
  localparam int unsigned YW = $clog2(GRID_H),
  localparam int unsigned AW = XW + YW
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               paint_valid,
  input  logic [AW-1:0]      player_pos_paint,
  input  logic [COLOR_W-1:0] paint_val_play,
  input  logic [AW-1:0]      new_wall_pos_paint,
  input  logic [COLOR_W-1:0] paint_val_wall,
  output logic               paint_ready,
  input  logic               clear_req,
  output logic               fb_we,
  output logic [AW-1:0]      fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               busy,
  output logic               overflow
);

  localparam int unsigned PW     = $clog2(FIFO_DEPTH);
  localparam int unsigned BEAT_W = 2 * (AW + COLOR_W);
  localparam logic [AW-1:0] LAST_CELL = AW'(GRID_W * GRID_H - 1);
  localparam logic [PW:0]   PTR_ONE   = (PW + 1)'(1);

  typedef enum logic [1:0] {StClear, StIdle, StWall, StPlay} state_e;

  state_e             state_q;
  logic [AW-1:0]      sweep_cnt_q;
  logic [PW:0]        wr_ptr_q, rd_ptr_q;
  logic [BEAT_W-1:0]  fifo_q [FIFO_DEPTH];

  logic               fifo_empty, fifo_full, push;
  logic [AW-1:0]      head_wall_pos, head_play_pos;
  logic [COLOR_W-1:0] head_wall_val, head_play_val;

  // Colour the clear sweep writes at a given {y,x} address.
  function automatic logic [COLOR_W-1:0] sweep_color(input logic [AW-1:0] addr);
`ifdef GRID_PAINT_BORDER_EN
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    x = addr[XW-1:0];
    y = addr[AW-1:XW];
    if (x == '0 || x == XW'(GRID_W - 1) || y == '0 || y == YW'(GRID_H - 1)) begin
      return BORDER_COLOR;
    end
    return BG_COLOR;
`else
    return (addr == addr) ? BG_COLOR : BG_COLOR;
`endif
  endfunction

  // Extra pointer bit distinguishes full from empty.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  assign paint_ready = (state_q != StClear) && !fifo_full && !clear_req;
  assign push        = paint_valid && paint_ready;
  assign busy        = (state_q != StIdle) || !fifo_empty;

  assign {head_wall_val, head_wall_pos, head_play_val, head_play_pos} =
      fifo_q[rd_ptr_q[PW-1:0]];

  // Storage needs no reset: pointers alone define occupancy.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[wr_ptr_q[PW-1:0]] <= {paint_val_wall, new_wall_pos_paint,
                                   paint_val_play, player_pos_paint};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StClear;
      sweep_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow    <= 1'b0;
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_data     <= '0;
    end else if (clear_req) begin
      // Restart: this edge already writes cell 0, and the sweep starts over from 0.
      state_q     <= StClear;
      sweep_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow    <= 1'b0;
      fb_we       <= 1'b1;
      fb_addr     <= '0;
      fb_data     <= sweep_color('0);
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (paint_valid && !paint_ready && state_q != StClear) begin
        overflow <= 1'b1;
      end
      unique case (state_q)
        StClear: begin
          fb_we       <= 1'b1;
          fb_addr     <= sweep_cnt_q;
          fb_data     <= sweep_color(sweep_cnt_q);
          sweep_cnt_q <= sweep_cnt_q + AW'(1);
          if (sweep_cnt_q == LAST_CELL) begin
            state_q <= StIdle;
          end
        end
        StIdle: begin
          fb_we <= 1'b0;
          if (!fifo_empty) begin
            state_q <= StWall;
          end
        end
        StWall: begin
          fb_we   <= 1'b1;
          fb_addr <= head_wall_pos;
          fb_data <= head_wall_val;
          state_q <= StPlay;
        end
        StPlay: begin
          fb_we    <= 1'b1;
          fb_addr  <= head_play_pos;
          fb_data  <= head_play_val;
          rd_ptr_q <= rd_ptr_q + PTR_ONE;
          // A beat pushed on this same edge keeps the FIFO non-empty.
          if (push || (wr_ptr_q != rd_ptr_q + PTR_ONE)) begin
            state_q <= StWall;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StClear;
          fb_we   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grid_paint_writer.sv
// Scoreboard bench for grid_paint_writer: stimulus pushes expected frame-buffer writes,
// a monitor pops and compares every fb_we cycle.
module tb_grid_paint_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        paint_valid = 1'b0;
  logic [11:0] player_pos_paint = '0;
  logic [3:0]  paint_val_play = '0;
  logic [11:0] new_wall_pos_paint = '0;
  logic [3:0]  paint_val_wall = '0;
  logic        paint_ready;
  logic        clear_req = 1'b0;
  logic        fb_we;
  logic [11:0] fb_addr;
  logic [3:0]  fb_data;
  logic        busy;
  logic        overflow;

  grid_paint_writer dut (
    .clock              (clock),
    .reset              (reset),
    .paint_valid        (paint_valid),
    .player_pos_paint   (player_pos_paint),
    .paint_val_play     (paint_val_play),
    .new_wall_pos_paint (new_wall_pos_paint),
    .paint_val_wall     (paint_val_wall),
    .paint_ready        (paint_ready),
    .clear_req          (clear_req),
    .fb_we              (fb_we),
    .fb_addr            (fb_addr),
    .fb_data            (fb_data),
    .busy               (busy),
    .overflow           (overflow)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [11:0] addr;
    logic [3:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  passed = 0;
  int  stalls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference sweep colour from the cell's row/column.
  function automatic logic [3:0] bg_of(input int a);
    int x, y;
    x = a % 64;
    y = a / 64;
`ifdef GRID_PAINT_BORDER_EN
    if (x == 0 || x == 63 || y == 0 || y == 63) return 4'hF;
    return 4'h0;
`else
    return (x + y >= 0) ? 4'h0 : 4'h0;
`endif
  endfunction

  task automatic push_sweep();
    for (int i = 0; i < 4096; i++) exp_q.push_back({12'(i), bg_of(i)});
  endtask

  // Monitor: every write the DUT presents must be the next expected one.
  initial begin
    wr_t e;
    forever begin
      @(posedge clock);
      #1;
      if (fb_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_write: got addr %0h data %0h, none expected", fb_addr, fb_data);
        end else begin
          e = exp_q.pop_front();
          check("fb_addr", 32'(fb_addr), 32'(e.addr));
          check("fb_data", 32'(fb_data), 32'(e.data));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the beat is accepted, valid still high.
  task automatic send(input logic [11:0] w, input logic [3:0] wv,
                      input logic [11:0] p, input logic [3:0] pv);
    int n;
    paint_valid = 1'b1;
    new_wall_pos_paint = w;
    paint_val_wall = wv;
    player_pos_paint = p;
    paint_val_play = pv;
    n = 0;
    forever begin
      #1;
      if (paint_ready === 1'b1) break;
      stalls++;
      n++;
      if (n > 100) begin
        checks++;
        $display("FAIL send_timeout: paint_ready stuck at %0b, required 1", paint_ready);
        paint_valid = 1'b0;
        return;
      end
      @(negedge clock);
    end
    exp_q.push_back({w, wv});
    exp_q.push_back({p, pv});
    @(negedge clock);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] w, p;
    repeat (2) @(negedge clock);
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_fb_data", 32'(fb_data), 32'd0);
    check("rst_ready", 32'(paint_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);

    reset = 1'b1;
    push_sweep();
    wait_idle("sweep", 5000);
    check("sweep_ready", 32'(paint_ready), 32'd1);
    check("sweep_overflow", 32'(overflow), 32'd0);

    // Single beat with latency check.
    @(negedge clock);
    paint_valid = 1'b1;
    new_wall_pos_paint = 12'h041;
    paint_val_wall = 4'h2;
    player_pos_paint = 12'h042;
    paint_val_play = 4'h0;
    #1;
    check("one_ready", 32'(paint_ready), 32'd1);
    exp_q.push_back({12'h041, 4'h2});
    exp_q.push_back({12'h042, 4'h0});
    @(posedge clock); #1;
    check("lat_n0_we", 32'(fb_we), 32'd0);
    @(negedge clock);
    paint_valid = 1'b0;
    @(posedge clock); #1;
    check("lat_n1_we", 32'(fb_we), 32'd0);
    @(posedge clock); #1;
    check("lat_n2_wall", {fb_we, 7'd0, fb_addr, 8'd0, fb_data}, {1'b1, 7'd0, 12'h041, 8'd0, 4'h2});
    @(posedge clock); #1;
    check("lat_n3_head", {fb_we, 7'd0, fb_addr, 8'd0, fb_data}, {1'b1, 7'd0, 12'h042, 8'd0, 4'h0});
    @(posedge clock); #1;
    check("lat_n4_we", 32'(fb_we), 32'd0);
    wait_idle("one", 50);

    // Random beats with random gaps; some with wall == head address.
    @(negedge clock);
    for (int i = 0; i < 40; i++) begin
      w = 12'($urandom);
      p = ($urandom_range(0, 7) == 0) ? w : 12'($urandom);
      send(w, 4'($urandom), p, 4'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        paint_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clock);
      end
    end
    paint_valid = 1'b0;
    wait_idle("rand", 500);

    // Fill: 12 beats back to back must stall and set overflow.
    stalls = 0;
    for (int i = 0; i < 12; i++) begin
      send(12'(i * 3), 4'(i), 12'(i * 3 + 1), 4'(15 - i));
    end
    paint_valid = 1'b0;
    check("fill_ready_dropped", 32'(stalls > 0), 32'd1);
    check("fill_overflow", 32'(overflow), 32'd1);
    wait_idle("fill", 200);

    // Three beats buffered, PLAY active, then clear_req held two edges.
    for (int i = 0; i < 3; i++) send(12'h100 + 12'(i), 4'h5, 12'h200 + 12'(i), 4'h6);
    check("pre_clear_busy", 32'(busy), 32'd1);
    paint_valid = 1'b0;
    clear_req = 1'b1;
    exp_q.delete();
    exp_q.push_back({12'h000, bg_of(0)});
    @(negedge clock);
    exp_q.push_back({12'h000, bg_of(0)});
    @(negedge clock);
    check("clear_overflow", 32'(overflow), 32'd0);
    clear_req = 1'b0;
    push_sweep();
    #1;
    check("clear_ready", 32'(paint_ready), 32'd0);
    check("clear_busy", 32'(busy), 32'd1);

    // Beats offered during the sweep are dropped without overflow.
    @(negedge clock);
    paint_valid = 1'b1;
    new_wall_pos_paint = 12'h7A5;
    paint_val_wall = 4'h9;
    player_pos_paint = 12'h5A7;
    paint_val_play = 4'hC;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (i % 5 == 0) check("sweep_ready_low", 32'(paint_ready), 32'd0);
      @(negedge clock);
    end
    paint_valid = 1'b0;
    wait_idle("resweep", 5000);
    check("resweep_overflow", 32'(overflow), 32'd0);
    check("resweep_ready", 32'(paint_ready), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
